l1_msg_responder: RTL and testbench

//  L1-side endpoint of the L2->L1 message interface; the cache drives, this block consumes.

---
 rtl/l1_msg_responder_pkg.sv | 25 ++
 rtl/l1_msg_fifo.sv | 46 ++++
 rtl/l1_msg_responder.sv | 134 +++++++++++++
 tb/tb_l1_msg_responder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/l1_msg_responder_pkg.sv
// Shared L2->L1 message types and responder FSM states.
// Message encodings match the cache-side l2tol1 interface.
package l1_msg_responder_pkg;

  typedef enum logic [1:0] {
    GETLINE        = 2'd0,
    SENDLINE       = 2'd1,
    INVALIDATELINE = 2'd2,
    EVICTLINE      = 2'd3
  } l2tol1_msg_e;

  typedef struct packed {
    l2tol1_msg_e msg;
    logic [31:0] address;
  } l2tol1_struct;

  localparam int NUM_L2TOL1_MSG = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_e;

endpackage

// File: rtl/l1_msg_fifo.sv
// Synchronous FIFO with first-word fall-through head.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module l1_msg_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty)
        rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage is not reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (rstb && push && !full)
      mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/l1_msg_responder.sv
// L1-side endpoint of the L2->L1 message interface: buffers, answers after a fixed
// latency, and tracks a shadow L1 presence table to flag inclusivity violations.
module l1_msg_responder
  import l1_msg_responder_pkg::*;
#(
  parameter int FIFO_DEPTH      = 4,
  parameter int RESP_LAT        = 2,
  parameter int LINE_OFF_BITS   = 6,
  parameter int SHADOW_IDX_BITS = 8,
  parameter int CNT_W           = 16
) (
  input  logic                                  clk,
  input  logic                                  rstb,
  input  logic                                  msg_valid,
  input  l2tol1_struct                          l2tol1msg_in,
  output logic                                  msg_ready,
  output logic                                  resp_valid,
  output l2tol1_msg_e                           resp_msg,
  output logic [31:0]                           resp_addr,
  output logic [NUM_L2TOL1_MSG-1:0][CNT_W-1:0]  msg_cntr,
  output logic [CNT_W-1:0]                      incl_err_cntr,
  output logic [CNT_W-1:0]                      ovf_cntr
);

  localparam int LAT_W      = $clog2(RESP_LAT + 1);
  localparam int TAG_W      = 32 - LINE_OFF_BITS - SHADOW_IDX_BITS;
  localparam int NUM_SHADOW = 1 << SHADOW_IDX_BITS;

  resp_state_e          state, next_state;
  logic [LAT_W-1:0]     cnt;
  l2tol1_msg_e          cur_msg;
  logic [31:0]          cur_addr;
  l2tol1_struct         fifo_head;
  logic                 fifo_full, fifo_empty, push, pop;

  logic [NUM_SHADOW-1:0]  shadow_valid;
  logic [TAG_W-1:0]       shadow_tag [NUM_SHADOW];
  logic [SHADOW_IDX_BITS-1:0] cur_idx;
  logic [TAG_W-1:0]       cur_tag;
  logic                   shadow_hit, incl_err;

  assign msg_ready = !fifo_full;
  assign push      = msg_valid && msg_ready;

  l1_msg_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(l2tol1_struct))
  ) u_fifo (
    .clk   (clk),
    .rstb  (rstb),
    .push  (push),
    .pop   (pop),
    .din   (l2tol1msg_in),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: if (!fifo_empty) begin
        pop        = 1'b1;
        next_state = WAIT;
      end
      WAIT: if (cnt == LAT_W'(1)) next_state = RESP;
      RESP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_msg  <= GETLINE;
      cur_addr <= '0;
    end else begin
      state <= next_state;
      if (pop) begin
        cur_msg  <= fifo_head.msg;
        cur_addr <= fifo_head.address;
        cnt      <= LAT_W'(RESP_LAT);
      end else if (state == WAIT) begin
        cnt <= cnt - LAT_W'(1);
      end
    end
  end

  assign resp_valid = (state == RESP);
  assign resp_msg   = cur_msg;
  assign resp_addr  = {cur_addr[31:LINE_OFF_BITS], LINE_OFF_BITS'(0)};

  assign cur_idx    = cur_addr[LINE_OFF_BITS +: SHADOW_IDX_BITS];
  assign cur_tag    = cur_addr[31 -: TAG_W];
  assign shadow_hit = shadow_valid[cur_idx] && (shadow_tag[cur_idx] == cur_tag);
  // INVALIDATELINE misses are legal: the L1 may have dropped the line silently.
  assign incl_err   = resp_valid && !shadow_hit &&
                      ((cur_msg == GETLINE) || (cur_msg == EVICTLINE));

  always_ff @(posedge clk) begin
    if (!rstb) begin
      shadow_valid <= '0;
    end else if (resp_valid) begin
      if (cur_msg == SENDLINE)
        shadow_valid[cur_idx] <= 1'b1;
      else if (((cur_msg == EVICTLINE) || (cur_msg == INVALIDATELINE)) && shadow_hit)
        shadow_valid[cur_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rstb && resp_valid && (cur_msg == SENDLINE))
      shadow_tag[cur_idx] <= cur_tag;
  end

  // All counters saturate at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      msg_cntr      <= '0;
      incl_err_cntr <= '0;
      ovf_cntr      <= '0;
    end else begin
      if (resp_valid && (msg_cntr[cur_msg] != '1))
        msg_cntr[cur_msg] <= msg_cntr[cur_msg] + CNT_W'(1);
      if (incl_err && (incl_err_cntr != '1))
        incl_err_cntr <= incl_err_cntr + CNT_W'(1);
      if (msg_valid && !msg_ready && (ovf_cntr != '1))
        ovf_cntr <= ovf_cntr + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_l1_msg_responder.sv
// Directed self-checking bench for l1_msg_responder with hand-computed expectations.
module tb_l1_msg_responder;
  import l1_msg_responder_pkg::*;

  logic                    clk = 1'b0;
  logic                    rstb;
  logic                    msg_valid;
  l2tol1_struct            l2tol1msg_in;
  logic                    msg_ready;
  logic                    resp_valid;
  l2tol1_msg_e             resp_msg;
  logic [31:0]             resp_addr;
  logic [3:0][15:0]        msg_cntr;
  logic [15:0]             incl_err_cntr;
  logic [15:0]             ovf_cntr;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int k;

  l2tol1_msg_e  seen_msg [$];
  logic [31:0]  seen_addr[$];
  int           seen_cyc [$];

  l1_msg_responder dut (
    .clk           (clk),
    .rstb          (rstb),
    .msg_valid     (msg_valid),
    .l2tol1msg_in  (l2tol1msg_in),
    .msg_ready     (msg_ready),
    .resp_valid    (resp_valid),
    .resp_msg      (resp_msg),
    .resp_addr     (resp_addr),
    .msg_cntr      (msg_cntr),
    .incl_err_cntr (incl_err_cntr),
    .ovf_cntr      (ovf_cntr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (resp_valid) begin
      seen_msg.push_back(resp_msg);
      seen_addr.push_back(resp_addr);
      seen_cyc.push_back(cyc);
    end
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called one step after a posedge; the push happens on the next posedge.
  task automatic apply_stimulus(input l2tol1_msg_e m, input logic [31:0] a);
    msg_valid            = 1'b1;
    l2tol1msg_in.msg     = m;
    l2tol1msg_in.address = a;
    @(posedge clk); #1;
    msg_valid = 1'b0;
  endtask

  task automatic do_reset();
    rstb      = 1'b0;
    msg_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstb = 1'b1;
    seen_msg.delete();
    seen_addr.delete();
    seen_cyc.delete();
  endtask

  task automatic wait_resp(input int n, input string tag);
    for (int i = 0; i < 100 && seen_msg.size() < n; i++) @(posedge clk);
    #1;
    check_output(tag, seen_msg.size(), n);
  endtask

  initial begin
    msg_valid    = 1'b0;
    l2tol1msg_in = '0;

    // 1: reset state and single SENDLINE latency
    do_reset();
    check_output("rst_resp_valid", resp_valid, 0);
    check_output("rst_resp_msg", resp_msg, GETLINE);
    check_output("rst_resp_addr", resp_addr, 0);
    check_output("rst_msg_ready", msg_ready, 1);
    check_output("rst_msg_cntr", msg_cntr, 0);
    check_output("rst_incl", incl_err_cntr, 0);
    check_output("rst_ovf", ovf_cntr, 0);
    apply_stimulus(SENDLINE, 32'h0000_1040);
    k = cyc;
    wait_resp(1, "t1_count");
    repeat (4) @(posedge clk);
    #1;
    check_output("t1_count_after", seen_msg.size(), 1);
    if (seen_msg.size() >= 1) begin
      check_output("t1_cycle", seen_cyc[0], k + 3);
      check_output("t1_addr", seen_addr[0], 32'h0000_1040);
      check_output("t1_msg", seen_msg[0], SENDLINE);
    end
    check_output("t1_cnt_send", msg_cntr[SENDLINE], 1);
    check_output("t1_shadow41", dut.shadow_valid[65], 1);
    check_output("t1_incl", incl_err_cntr, 0);

    // 2: evict hit then evict miss; unaligned address gets offset cleared
    do_reset();
    apply_stimulus(SENDLINE, 32'h0000_1040);
    apply_stimulus(EVICTLINE, 32'h0000_1040);
    apply_stimulus(EVICTLINE, 32'h0000_105F);
    wait_resp(3, "t2_count");
    repeat (3) @(posedge clk);
    #1;
    check_output("t2_incl", incl_err_cntr, 1);
    check_output("t2_cnt_evict", msg_cntr[EVICTLINE], 2);
    check_output("t2_cnt_send", msg_cntr[SENDLINE], 1);
    if (seen_addr.size() >= 3) check_output("t2_align", seen_addr[2], 32'h0000_1040);

    // 3: GETLINE miss is an error, INVALIDATELINE miss is not
    do_reset();
    apply_stimulus(GETLINE, 32'h0000_2000);
    wait_resp(1, "t3_count_get");
    repeat (3) @(posedge clk);
    #1;
    check_output("t3_incl_get", incl_err_cntr, 1);
    apply_stimulus(INVALIDATELINE, 32'h0000_3000);
    wait_resp(2, "t3_count_inv");
    repeat (3) @(posedge clk);
    #1;
    check_output("t3_incl_inv", incl_err_cntr, 1);
    check_output("t3_cnt_inv", msg_cntr[INVALIDATELINE], 1);
    check_output("t3_cnt_get", msg_cntr[GETLINE], 1);

    // 4: six back-to-back pushes into a depth-4 FIFO
    do_reset();
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(SENDLINE, 32'h1000 * (i + 1));
      if (i == 0) k = cyc;
      if (i == 4) check_output("t4_ready_full", msg_ready, 0);
    end
    check_output("t4_ovf", ovf_cntr, 1);
    wait_resp(5, "t4_count");
    repeat (8) @(posedge clk);
    #1;
    check_output("t4_count_after", seen_msg.size(), 5);
    for (int i = 0; i < 5 && i < seen_msg.size(); i++) begin
      check_output($sformatf("t4_addr%0d", i), seen_addr[i], 32'h1000 * (i + 1));
      check_output($sformatf("t4_cyc%0d", i), seen_cyc[i], k + 3 + 4 * i);
    end
    check_output("t4_cnt_send", msg_cntr[SENDLINE], 5);
    check_output("t4_ready_end", msg_ready, 1);

    // 5: tag replacement in the same shadow index
    do_reset();
    apply_stimulus(SENDLINE, 32'h0000_1040);
    apply_stimulus(SENDLINE, 32'h0004_1040);
    apply_stimulus(GETLINE, 32'h0000_1040);
    wait_resp(3, "t5_count");
    repeat (3) @(posedge clk);
    #1;
    check_output("t5_incl", incl_err_cntr, 1);

    // 6: reset while the message is in WAIT
    do_reset();
    apply_stimulus(GETLINE, 32'h0000_2000);
    @(posedge clk); #1;
    rstb = 1'b0;
    @(posedge clk); #1;
    rstb = 1'b1;
    check_output("t6_resp_valid", resp_valid, 0);
    check_output("t6_ready", msg_ready, 1);
    repeat (8) @(posedge clk);
    #1;
    check_output("t6_no_resp", seen_msg.size(), 0);
    check_output("t6_msg_cntr", msg_cntr, 0);
    check_output("t6_incl", incl_err_cntr, 0);
    check_output("t6_ovf", ovf_cntr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
